sa_tx_wr_arb: RTL and testbench
===============================

// Module: sa_tx_wr_arb
// PURPOSE
//  Parametrised N-channel write merger in front of the TX buffer. Each channel
//  writes (addr,data) into its own DEPTH-entry FIFO; a round-robin arbiter drains
//  one entry per cycle into a single registered TX-buffer write port. Replaces
//  the two-source OR merge: simultaneous writes are serialised, not OR-corrupted.
// PARAMETERS
//  NUM_CH   2   number of write channels (>=2)
//  CH_W     1   width of channel index, = clog2(NUM_CH)
//  AW       11  TX-buffer address width
//  DW       8   TX-buffer data width
//  DEPTH    4   per-channel FIFO entries (power of 2, >=2)
// PORTS
//  sys_clk         in   1          system clock; all logic on rising edge
//  glbl_rst        in   1          synchronous reset, active-high
//  ch_wren         in   NUM_CH     per-channel write strobe, 1-cycle pulse per word
//  ch_waddr        in   NUM_CH*AW  channel i address at [i*AW +: AW]
//  ch_wdata        in   NUM_CH*DW  channel i data at [i*DW +: DW]
//  ch_full         out  NUM_CH     channel FIFO holds DEPTH entries
//  ch_ovf          out  NUM_CH     sticky: a write to a full channel was dropped
//  ovf_clr         in   1          clears all ch_ovf bits
//  tx_buff_wren    out  1          TX-buffer write strobe
//  tx_buff_wraddr  out  AW         TX-buffer write address
//  tx_buff_wrdata  out  DW         TX-buffer write data
//  tx_gnt_ch       out  CH_W       channel index of current tx_buff_* write
// BEHAVIOUR
//  Reset (glbl_rst=1 at edge): all FIFOs empty, counts 0; every output 0;
//   rr_ptr=NUM_CH-1 so channel 0 has first priority. Reset overrides all inputs;
//   entries in flight are discarded, no write is issued in the reset cycle.
//  Push: at edge k, ch_wren[i]=1 and count_i<DEPTH -> entry stored, count_i+1.
//   count_i==DEPTH -> word dropped, ch_ovf[i] set; a pop on channel i in the
//   same cycle does NOT make room (full decision uses pre-edge count).
//  ch_full[i] = (count_i==DEPTH), registered-state derived, no comb path from ch_wren.
//  Arbitration (each cycle, from FIFO state before edge): candidates = channels
//   with count>0; grant first candidate searching rr_ptr+1, rr_ptr+2 ... modulo
//   NUM_CH. On grant g: pop head of g, rr_ptr<=g. No candidate: rr_ptr holds.
//  Output register: at edge, tx_buff_wren<=grant_valid; wraddr/wrdata/gnt_ch
//   <=head of granted FIFO when granted, else hold previous values (wren=0).
//  Latency: word pushed at edge k on an idle block appears with tx_buff_wren=1
//   after edge k+1 (2 edges, no comb bypass). Throughput 1 word/cycle total.
//  Simultaneous push+pop on same channel (not full): count unchanged, order kept.
//  Ordering: strict FIFO within a channel; no order guarantee across channels.
//  Fairness: with all channels backlogged, grants rotate 0,1,..,NUM_CH-1,0..
//  ch_ovf[i]: set on dropped write, cleared by ovf_clr; set and clr same
//   edge -> set wins (bit stays 1).
//  FIFO pointers wrap modulo DEPTH; count width clog2(DEPTH)+1.
// TESTING
//  1 Reset: hold glbl_rst 3 cycles with ch_wren=all-1 -> all outputs 0,
//    ch_full=0, no tx_buff_wren during or 1 cycle after release.
//  2 Single write: ch0 addr 0x012 data 0xA5 at edge k -> tx_buff_wren=1,
//    addr 0x012, data 0xA5, gnt_ch=0 after edge k+1, for exactly 1 cycle.
//  3 Collision: ch0 (0x001,0x11) and ch1 (0x002,0x22) same edge -> two
//    consecutive writes, ch0 then ch1; never 0x003/0x33 on the bus.
//  4 Fairness: both channels push every cycle for 20 cycles -> grants
//    alternate 0,1,0,1; ch_full rises, later writes dropped, ch_ovf=2'b11.
//  5 Overflow: fill ch1 with 4 words while output stalled by ch0 backlog,
//    5th write dropped, ch_ovf[1]=1; ovf_clr pulse -> 0; clr+drop same edge -> 1.
//  6 Reset mid-operation: glbl_rst with 3 entries queued -> queue flushed,
//    no queued word appears after release; rr restarts at channel 0.

Source files
------------

// File: rtl/sa_tx_wr_arb.sv
// rtl/sa_tx_wr_arb.sv - N-channel write merger: per-channel FIFOs drained round-robin into one TX-buffer write port
module sa_tx_wr_arb #(
  parameter int NUM_CH = 2,
  parameter int CH_W   = 1,
  parameter int AW     = 11,
  parameter int DW     = 8,
  parameter int DEPTH  = 4
) (
  input  logic                 sys_clk,
  input  logic                 glbl_rst,
  input  logic [NUM_CH-1:0]    ch_wren,
  input  logic [NUM_CH*AW-1:0] ch_waddr,
  input  logic [NUM_CH*DW-1:0] ch_wdata,
  output logic [NUM_CH-1:0]    ch_full,
  output logic [NUM_CH-1:0]    ch_ovf,
  input  logic                 ovf_clr,
  output logic                 tx_buff_wren,
  output logic [AW-1:0]        tx_buff_wraddr,
  output logic [DW-1:0]        tx_buff_wrdata,
  output logic [CH_W-1:0]      tx_gnt_ch
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [AW-1:0]    fifo_addr [NUM_CH][DEPTH];
  logic [DW-1:0]    fifo_data [NUM_CH][DEPTH];
  logic [PTR_W-1:0] wr_ptr    [NUM_CH];
  logic [PTR_W-1:0] rd_ptr    [NUM_CH];
  logic [CNT_W-1:0] count     [NUM_CH];
  logic [CH_W-1:0]  rr_ptr;

  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;
  logic              grant_valid;
  logic [CH_W-1:0]   grant_ch;
  logic [CH_W-1:0]   cand;

  // Channel index rr_ptr+off modulo NUM_CH; off never exceeds NUM_CH so one fold is enough.
  function automatic logic [CH_W-1:0] rr_next(input logic [CH_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_CH) sum = sum - NUM_CH;
    return CH_W'(sum);
  endfunction

  // Round-robin search starting just after the last granted channel, on pre-edge FIFO state.
  always_comb begin
    grant_valid = 1'b0;
    grant_ch    = '0;
    cand        = '0;
    for (int off = 1; off <= NUM_CH; off++) begin
      cand = rr_next(rr_ptr, off);
      if (!grant_valid && (count[cand] != '0)) begin
        grant_valid = 1'b1;
        grant_ch    = cand;
      end
    end
  end

  // Full flag comes from the registered count only; a same-cycle pop never makes room.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      ch_full[i] = (count[i] == CNT_FULL);
      push[i]    = ch_wren[i] && (count[i] != CNT_FULL);
      pop[i]     = grant_valid && (grant_ch == CH_W'(i));
    end
  end

  // FIFO storage; no reset needed because the pointers define what is valid.
  always_ff @(posedge sys_clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (push[i]) begin
        fifo_addr[i][wr_ptr[i]] <= ch_waddr[i*AW +: AW];
        fifo_data[i][wr_ptr[i]] <= ch_wdata[i*DW +: DW];
      end
    end
  end

  // Pointer, occupancy, overflow-flag and round-robin state.
  always_ff @(posedge sys_clk) begin
    if (glbl_rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
      ch_ovf <= '0;
      rr_ptr <= CH_W'(NUM_CH - 1);
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
        if (push[i] && !pop[i]) begin
          count[i] <= count[i] + CNT_W'(1);
        end else if (!push[i] && pop[i]) begin
          count[i] <= count[i] - CNT_W'(1);
        end
        // A drop in the same cycle as a clear keeps the flag set.
        if (ch_wren[i] && (count[i] == CNT_FULL)) begin
          ch_ovf[i] <= 1'b1;
        end else if (ovf_clr) begin
          ch_ovf[i] <= 1'b0;
        end
      end
      if (grant_valid) rr_ptr <= grant_ch;
    end
  end

  // Registered TX-buffer write port; address/data/channel hold when idle.
  always_ff @(posedge sys_clk) begin
    if (glbl_rst) begin
      tx_buff_wren   <= 1'b0;
      tx_buff_wraddr <= '0;
      tx_buff_wrdata <= '0;
      tx_gnt_ch      <= '0;
    end else begin
      tx_buff_wren <= grant_valid;
      if (grant_valid) begin
        tx_buff_wraddr <= fifo_addr[grant_ch][rd_ptr[grant_ch]];
        tx_buff_wrdata <= fifo_data[grant_ch][rd_ptr[grant_ch]];
        tx_gnt_ch      <= grant_ch;
      end
    end
  end

endmodule

// File: tb/tb_sa_tx_wr_arb.sv
// tb/tb_sa_tx_wr_arb.sv - self-checking bench for sa_tx_wr_arb
module tb_sa_tx_wr_arb;

  localparam int NUM_CH = 2;
  localparam int CH_W   = 1;
  localparam int AW     = 11;
  localparam int DW     = 8;
  localparam int DEPTH  = 4;

  logic                 sys_clk = 1'b0;
  logic                 glbl_rst;
  logic [NUM_CH-1:0]    ch_wren;
  logic [NUM_CH*AW-1:0] ch_waddr;
  logic [NUM_CH*DW-1:0] ch_wdata;
  logic [NUM_CH-1:0]    ch_full;
  logic [NUM_CH-1:0]    ch_ovf;
  logic                 ovf_clr;
  logic                 tx_buff_wren;
  logic [AW-1:0]        tx_buff_wraddr;
  logic [DW-1:0]        tx_buff_wrdata;
  logic [CH_W-1:0]      tx_gnt_ch;

  always #5 sys_clk = ~sys_clk;

  sa_tx_wr_arb #(
    .NUM_CH(NUM_CH), .CH_W(CH_W), .AW(AW), .DW(DW), .DEPTH(DEPTH)
  ) dut (
    .sys_clk        (sys_clk),
    .glbl_rst       (glbl_rst),
    .ch_wren        (ch_wren),
    .ch_waddr       (ch_waddr),
    .ch_wdata       (ch_wdata),
    .ch_full        (ch_full),
    .ch_ovf         (ch_ovf),
    .ovf_clr        (ovf_clr),
    .tx_buff_wren   (tx_buff_wren),
    .tx_buff_wraddr (tx_buff_wraddr),
    .tx_buff_wrdata (tx_buff_wrdata),
    .tx_gnt_ch      (tx_gnt_ch)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ent_t;

  typedef struct {
    logic          rst;
    logic [1:0]    wren;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic          clr;
    logic          e_wren;
    logic          e_gnt;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    logic [1:0]    e_full;
    logic [1:0]    e_ovf;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  ent_t          m_q [NUM_CH][$];
  int            m_cnt [NUM_CH];
  int            m_rr;
  logic          m_wren;
  int            m_gnt;
  logic [1:0]    m_ovf;
  logic [AW-1:0] last_addr;
  logic [DW-1:0] last_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rst, input logic [1:0] wren,
                              input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                              input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                              input logic clr, input logic e_wren, input logic e_gnt,
                              input logic [AW-1:0] e_addr, input logic [DW-1:0] e_data,
                              input logic [1:0] e_full, input logic [1:0] e_ovf);
    vec_t v;
    v.rst = rst; v.wren = wren; v.a0 = a0; v.d0 = d0; v.a1 = a1; v.d1 = d1; v.clr = clr;
    v.e_wren = e_wren; v.e_gnt = e_gnt; v.e_addr = e_addr; v.e_data = e_data;
    v.e_full = e_full; v.e_ovf = e_ovf;
    return v;
  endfunction

  task automatic drive(input logic rst, input logic [1:0] wren,
                       input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                       input logic clr);
    glbl_rst = rst;
    ch_wren  = wren;
    ch_waddr = {a1, a0};
    ch_wdata = {d1, d0};
    ovf_clr  = clr;
  endtask

  // Advance the reference model on the driven inputs, clock one edge, compare against the scoreboard.
  task automatic tick();
    logic       gv;
    int         g;
    int         c;
    logic [1:0] drop;
    ent_t       e;
    gv = 1'b0; g = 0; drop = '0;
    if (glbl_rst) begin
      for (c = 0; c < NUM_CH; c++) begin
        m_q[c].delete();
        m_cnt[c] = 0;
      end
      m_ovf = '0; m_rr = NUM_CH - 1; m_wren = 1'b0; m_gnt = 0;
      last_addr = '0; last_data = '0;
    end else begin
      for (int off = 1; off <= NUM_CH; off++) begin
        c = (m_rr + off) % NUM_CH;
        if (!gv && m_cnt[c] > 0) begin
          gv = 1'b1;
          g  = c;
        end
      end
      for (c = 0; c < NUM_CH; c++) begin
        if (ch_wren[c]) begin
          if (m_cnt[c] == DEPTH) begin
            drop[c] = 1'b1;
          end else begin
            e.addr = ch_waddr[c*AW +: AW];
            e.data = ch_wdata[c*DW +: DW];
            m_q[c].push_back(e);
            m_cnt[c]++;
          end
        end
      end
      if (gv) begin
        m_cnt[g]--;
        m_rr  = g;
        m_gnt = g;
      end
      m_wren = gv;
      for (c = 0; c < NUM_CH; c++) begin
        if (drop[c]) m_ovf[c] = 1'b1;
        else if (ovf_clr) m_ovf[c] = 1'b0;
      end
    end
    @(posedge sys_clk);
    #1;
    check("sb_wren", tx_buff_wren, m_wren);
    if (m_wren) begin
      check("sb_gnt", tx_gnt_ch, m_gnt);
      check("sb_q_nonempty", m_q[m_gnt].size() > 0, 1);
      if (m_q[m_gnt].size() > 0) begin
        e = m_q[m_gnt].pop_front();
        last_addr = e.addr;
        last_data = e.data;
      end
    end
    check("sb_addr", tx_buff_wraddr, last_addr);
    check("sb_data", tx_buff_wrdata, last_data);
    for (c = 0; c < NUM_CH; c++) check("sb_full", ch_full[c], m_cnt[c] == DEPTH);
    check("sb_ovf", ch_ovf, m_ovf);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t       vecs[$];
    logic [1:0] saw_full;
    logic       prev_ok;
    logic       prev_gnt;
    int         n;

    glbl_rst = 1'b1; ch_wren = '0; ch_waddr = '0; ch_wdata = '0; ovf_clr = 1'b0;

    // Reset with writes asserted, release, single write, collision after a fresh reset.
    vecs.push_back(mk(1, 2'b11, 11'h7FF, 8'hFF, 11'h7FE, 8'hEE, 0, 0, 0, 11'h000, 8'h00, 2'b00, 2'b00));
    vecs.push_back(mk(1, 2'b11, 11'h7FF, 8'hFF, 11'h7FE, 8'hEE, 0, 0, 0, 11'h000, 8'h00, 2'b00, 2'b00));
    vecs.push_back(mk(1, 2'b11, 11'h7FF, 8'hFF, 11'h7FE, 8'hEE, 0, 0, 0, 11'h000, 8'h00, 2'b00, 2'b00));
    vecs.push_back(mk(0, 2'b00, 11'h000, 8'h00, 11'h000, 8'h00, 0, 0, 0, 11'h000, 8'h00, 2'b00, 2'b00));
    vecs.push_back(mk(0, 2'b01, 11'h012, 8'hA5, 11'h000, 8'h00, 0, 0, 0, 11'h000, 8'h00, 2'b00, 2'b00));
    vecs.push_back(mk(0, 2'b00, 11'h000, 8'h00, 11'h000, 8'h00, 0, 1, 0, 11'h012, 8'hA5, 2'b00, 2'b00));
    vecs.push_back(mk(0, 2'b00, 11'h000, 8'h00, 11'h000, 8'h00, 0, 0, 0, 11'h012, 8'hA5, 2'b00, 2'b00));
    vecs.push_back(mk(1, 2'b00, 11'h000, 8'h00, 11'h000, 8'h00, 0, 0, 0, 11'h000, 8'h00, 2'b00, 2'b00));
    vecs.push_back(mk(0, 2'b11, 11'h001, 8'h11, 11'h002, 8'h22, 0, 0, 0, 11'h000, 8'h00, 2'b00, 2'b00));
    vecs.push_back(mk(0, 2'b00, 11'h000, 8'h00, 11'h000, 8'h00, 0, 1, 0, 11'h001, 8'h11, 2'b00, 2'b00));
    vecs.push_back(mk(0, 2'b00, 11'h000, 8'h00, 11'h000, 8'h00, 0, 1, 1, 11'h002, 8'h22, 2'b00, 2'b00));
    vecs.push_back(mk(0, 2'b00, 11'h000, 8'h00, 11'h000, 8'h00, 0, 0, 1, 11'h002, 8'h22, 2'b00, 2'b00));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].wren, vecs[i].a0, vecs[i].d0, vecs[i].a1, vecs[i].d1, vecs[i].clr);
      tick();
      check($sformatf("vec%0d_wren", i), tx_buff_wren,   vecs[i].e_wren);
      check($sformatf("vec%0d_gnt",  i), tx_gnt_ch,      vecs[i].e_gnt);
      check($sformatf("vec%0d_addr", i), tx_buff_wraddr, vecs[i].e_addr);
      check($sformatf("vec%0d_data", i), tx_buff_wrdata, vecs[i].e_data);
      check($sformatf("vec%0d_full", i), ch_full,        vecs[i].e_full);
      check($sformatf("vec%0d_ovf",  i), ch_ovf,         vecs[i].e_ovf);
    end

    // Fairness: both channels push every cycle; grants must alternate and both FIFOs overflow.
    drive(1, 2'b00, 0, 0, 0, 0, 0); tick();
    saw_full = '0; prev_ok = 1'b0; prev_gnt = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive(0, 2'b11, 11'h100 + 11'(i), 8'(i), 11'h200 + 11'(i), 8'h80 + 8'(i), 0);
      tick();
      saw_full = saw_full | ch_full;
      if (tx_buff_wren) begin
        if (prev_ok) check("fair_alt", tx_gnt_ch != prev_gnt, 1);
        prev_gnt = tx_gnt_ch;
        prev_ok  = 1'b1;
      end
    end
    check("fair_full_seen", saw_full, 2'b11);
    check("fair_ovf", ch_ovf, 2'b11);
    drive(0, 2'b00, 0, 0, 0, 0, 0);
    repeat (12) tick();
    check("fair_drained", m_q[0].size() + m_q[1].size(), 0);
    check("fair_idle", tx_buff_wren, 0);

    // Overflow on ch1 while ch0 competes for the port; clear and set-wins behaviour.
    drive(1, 2'b00, 0, 0, 0, 0, 0); tick();
    n = 0;
    while (ch_full[1] !== 1'b1 && n < 30) begin
      drive(0, 2'b11, 11'h300 + 11'(n), 8'h30 + 8'(n), 11'h400 + 11'(n), 8'h40 + 8'(n), 0);
      tick();
      n++;
    end
    check("ovf_fill_ch1", ch_full[1], 1);
    check("ovf_none_yet", ch_ovf[1], 0);
    drive(0, 2'b11, 11'h3AA, 8'h5A, 11'h4BB, 8'h6B, 1); tick();
    check("ovf_set_wins", ch_ovf[1], 1);
    drive(0, 2'b00, 0, 0, 0, 0, 1); tick();
    check("ovf_cleared", ch_ovf, 2'b00);
    drive(0, 2'b00, 0, 0, 0, 0, 0);
    repeat (12) tick();

    // Reset with three entries queued: nothing queued may come out, arbitration restarts at ch0.
    drive(1, 2'b00, 0, 0, 0, 0, 0); tick();
    drive(0, 2'b11, 11'h501, 8'hC1, 11'h601, 8'hD1, 0); tick();
    drive(0, 2'b11, 11'h502, 8'hC2, 11'h602, 8'hD2, 0); tick();
    drive(1, 2'b11, 11'h503, 8'hC3, 11'h603, 8'hD3, 0); tick();
    check("mid_rst_wren", tx_buff_wren, 0);
    check("mid_rst_addr", tx_buff_wraddr, 0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 2'b00, 0, 0, 0, 0, 0); tick();
      check("mid_flushed", tx_buff_wren, 0);
    end
    drive(0, 2'b11, 11'h0AA, 8'h01, 11'h0BB, 8'h02, 0); tick();
    check("mid_latency", tx_buff_wren, 0);
    drive(0, 2'b00, 0, 0, 0, 0, 0); tick();
    check("mid_rr_wren0", tx_buff_wren, 1);
    check("mid_rr_first", tx_gnt_ch, 0);
    check("mid_rr_addr0", tx_buff_wraddr, 11'h0AA);
    tick();
    check("mid_rr_wren1", tx_buff_wren, 1);
    check("mid_rr_second", tx_gnt_ch, 1);
    check("mid_rr_data1", tx_buff_wrdata, 8'h02);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
